// File: rtl/digit_chain_pkg.sv
// Shared constants and helpers for the cascaded up/down digit counter.
package digit_chain_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [15:0] MAXV_DEFAULT = 16'h5959;

  typedef enum logic [1:0] {
    DIG_HOLD,
    DIG_CLEAR,
    DIG_LOAD,
    DIG_STEP
  } digit_op_e;

  // Limit a loaded digit so it never starts outside its own wrap range.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] v,
    input logic [DIGIT_W-1:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One 4-bit wrap counter (0..MAX_V) with clear, clamped load and directional step.
// Down-counting is only built when UPDOWN_DIGIT_CHAIN_DOWN_EN is defined.
module mod_digit
  import digit_chain_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_V = 4'd9
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] value,
  output logic               terminal
);

  localparam logic [DIGIT_W-1:0] ONE = DIGIT_W'(1);

  logic [DIGIT_W-1:0] value_reg;
  logic [DIGIT_W-1:0] value_next;
  digit_op_e          op;
  logic               at_max;

  assign at_max = (value_reg == MAX_V);

`ifdef UPDOWN_DIGIT_CHAIN_DOWN_EN
  logic at_zero;
  assign at_zero  = (value_reg == '0);
  assign terminal = up ? at_max : at_zero;
`else
  logic unused_up;
  assign unused_up = up;
  assign terminal  = at_max;
`endif

  always_comb begin
    op = DIG_HOLD;
    if (clear) begin
      op = DIG_CLEAR;
    end else if (load) begin
      op = DIG_LOAD;
    end else if (step) begin
      op = DIG_STEP;
    end
  end

  always_comb begin
    value_next = value_reg;
    unique case (op)
      DIG_CLEAR: value_next = '0;
      DIG_LOAD:  value_next = clamp_digit(load_value, MAX_V);
      DIG_STEP: begin
`ifdef UPDOWN_DIGIT_CHAIN_DOWN_EN
        if (up) begin
          value_next = at_max ? '0 : value_reg + ONE;
        end else begin
          value_next = at_zero ? MAX_V : value_reg - ONE;
        end
`else
        value_next = at_max ? '0 : value_reg + ONE;
`endif
      end
      default: value_next = value_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/updown_digit_chain.sv
// Chain of NDIG wrap digits resolving the full ripple in one cycle, with cascade Carry and sticky Ovf.
// Down-counting is compiled in only with UPDOWN_DIGIT_CHAIN_DOWN_EN; otherwise Up is ignored.
module updown_digit_chain
  import digit_chain_pkg::*;
#(
  parameter int                        NDIG = 4,
  parameter logic [DIGIT_W*NDIG-1:0]   MAXV = (DIGIT_W*NDIG)'(MAXV_DEFAULT)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Up,
  input  logic                    Clear,
  input  logic                    Load,
  input  logic [DIGIT_W*NDIG-1:0] LoadValue,
  output logic [DIGIT_W*NDIG-1:0] Salida,
  output logic                    Carry,
  output logic                    Ovf
);

  logic            up_eff;
  logic [NDIG-1:0] terminal;
  logic [NDIG:0]   below_term;
  logic            ovf_reg;
  logic            ovf_next;

`ifdef UPDOWN_DIGIT_CHAIN_DOWN_EN
  assign up_eff = Up;
`else
  logic unused_up;
  assign unused_up = Up;
  assign up_eff    = 1'b1;
`endif

  // below_term[k] is high when every digit under k sits at its terminal value.
  assign below_term[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign below_term[gi+1] = below_term[gi] & terminal[gi];

      mod_digit #(
        .MAX_V(MAXV[gi*DIGIT_W +: DIGIT_W])
      ) u_digit (
        .clk       (Clock),
        .srst      (Reset),
        .clear     (Clear),
        .load      (Load),
        .load_value(LoadValue[gi*DIGIT_W +: DIGIT_W]),
        .step      (Enable & below_term[gi]),
        .up        (up_eff),
        .value     (Salida[gi*DIGIT_W +: DIGIT_W]),
        .terminal  (terminal[gi])
      );
    end
  endgenerate

  assign Carry = Enable & ~Clear & ~Load & below_term[NDIG];

  always_comb begin
    ovf_next = ovf_reg;
    if (Clear) begin
      ovf_next = 1'b0;
    end else if (Load) begin
      ovf_next = ovf_reg;
    end else if (Carry) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign Ovf = ovf_reg;

endmodule

// File: tb/tb_updown_digit_chain.sv
// Randomized self-checking bench for updown_digit_chain against a mixed-radix integer model.
module tb_updown_digit_chain;

  localparam int          NDIG = 4;
  localparam logic [15:0] MAXV = 16'h5959;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        Up = 1'b0;
  logic        Clear = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] LoadValue = '0;
  logic [15:0] Salida;
  logic        Carry;
  logic        Ovf;

  int errors = 0;
  int checks = 0;
  int m_idx = 0;
  int m_ovf = 0;
  int cyc = 0;
  logic last_carry = 1'b0;
  logic carry_seen = 1'b0;

  updown_digit_chain #(
    .NDIG(NDIG),
    .MAXV(MAXV)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .Up       (Up),
    .Clear    (Clear),
    .Load     (Load),
    .LoadValue(LoadValue),
    .Salida   (Salida),
    .Carry    (Carry),
    .Ovf      (Ovf)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int radix(input int k);
    logic [15:0] m;
    m = MAXV;
    return int'(m[4*k +: 4]) + 1;
  endfunction

  function automatic int total_count();
    int t;
    t = 1;
    for (int k = 0; k < NDIG; k++) t *= radix(k);
    return t;
  endfunction

  function automatic int to_index(input logic [15:0] v);
    int idx;
    int w;
    idx = 0;
    w = 1;
    for (int k = 0; k < NDIG; k++) begin
      idx += int'(v[4*k +: 4]) * w;
      w *= radix(k);
    end
    return idx;
  endfunction

  function automatic logic [15:0] from_index(input int idx);
    logic [15:0] v;
    int r;
    v = '0;
    r = idx;
    for (int k = 0; k < NDIG; k++) begin
      v[4*k +: 4] = 4'(r % radix(k));
      r = r / radix(k);
    end
    return v;
  endfunction

  function automatic logic [15:0] clamp_all(input logic [15:0] v);
    logic [15:0] c;
    logic [15:0] m;
    m = MAXV;
    c = v;
    for (int k = 0; k < NDIG; k++)
      if (c[4*k +: 4] > m[4*k +: 4]) c[4*k +: 4] = m[4*k +: 4];
    return c;
  endfunction

  task automatic step(input logic rst, input logic clr, input logic ld, input logic en,
                      input logic up, input logic [15:0] lv);
    logic up_eff;
    logic exp_carry;
    int total;
    @(negedge Clock);
    Reset = rst;
    Clear = clr;
    Load = ld;
    Enable = en;
    Up = up;
    LoadValue = lv;
`ifdef UPDOWN_DIGIT_CHAIN_DOWN_EN
    up_eff = up;
`else
    up_eff = 1'b1;
`endif
    total = total_count();
    exp_carry = en && !clr && !ld && (up_eff ? (m_idx == total - 1) : (m_idx == 0));
    #2;
    last_carry = Carry;
    if (Carry) carry_seen = 1'b1;
    check_val("carry", {31'b0, Carry}, {31'b0, exp_carry});
    if (rst) begin
      m_idx = 0;
      m_ovf = 0;
    end else if (clr) begin
      m_idx = 0;
      m_ovf = 0;
    end else if (ld) begin
      m_idx = to_index(clamp_all(lv));
    end else if (en) begin
      m_idx = up_eff ? (m_idx + 1) % total : (m_idx + total - 1) % total;
      if (exp_carry) m_ovf = 1;
    end
    @(posedge Clock);
    #1;
    cyc++;
    check_val("salida", {16'b0, Salida}, {16'b0, from_index(m_idx)});
    check_val("ovf", {31'b0, Ovf}, m_ovf[31:0]);
    $display("cyc=%0d rst=%b clr=%b ld=%b en=%b up=%b lv=%h -> salida=%h carry=%b ovf=%b",
             cyc, rst, clr, ld, en, up, lv, Salida, last_carry, Ovf);
  endtask

  initial begin
    logic [15:0] lv;
    int r;

    // Reset wins over every other input.
    step(1, 1, 1, 1, 1, 16'hFFFF);
    check_val("rst_salida", {16'b0, Salida}, 32'h0);
    check_val("rst_ovf", {31'b0, Ovf}, 32'h0);

    step(0, 0, 0, 1, 1, 16'h0000);
    check_val("first_enable", {16'b0, Salida}, 32'h0001);

    // 600 ticks of mm:ss from zero.
    step(1, 0, 0, 0, 1, 16'h0000);
    carry_seen = 1'b0;
    repeat (600) step(0, 0, 0, 1, 1, 16'h0000);
    check_val("t600_salida", {16'b0, Salida}, 32'h1000);
    check_val("t600_no_carry", {31'b0, carry_seen}, 32'h0);

    step(0, 0, 1, 0, 1, 16'hF9A3);
    check_val("load_clamp", {16'b0, Salida}, 32'h5953);

    step(0, 0, 1, 0, 1, 16'h5959);
    step(0, 0, 0, 0, 1, 16'h0000);
    check_val("hold_salida", {16'b0, Salida}, 32'h5959);
    step(0, 0, 0, 1, 1, 16'h0000);
    check_val("wrap_carry", {31'b0, last_carry}, 32'h1);
    check_val("wrap_salida", {16'b0, Salida}, 32'h0000);
    check_val("wrap_ovf", {31'b0, Ovf}, 32'h1);

    step(0, 0, 1, 0, 1, 16'h0427);
    check_val("load_keeps_ovf", {31'b0, Ovf}, 32'h1);
    step(1, 1, 1, 1, 1, 16'h0427);
    check_val("all_high_salida", {16'b0, Salida}, 32'h0000);
    check_val("all_high_ovf", {31'b0, Ovf}, 32'h0);

`ifdef UPDOWN_DIGIT_CHAIN_DOWN_EN
    step(0, 1, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0000);
    check_val("down_carry", {31'b0, last_carry}, 32'h1);
    check_val("down_salida", {16'b0, Salida}, 32'h5959);
    check_val("down_ovf", {31'b0, Ovf}, 32'h1);
`else
    step(0, 0, 1, 0, 1, 16'h0009);
    step(0, 0, 0, 1, 0, 16'h0000);
    check_val("up_ignored", {16'b0, Salida}, 32'h0010);
`endif

    repeat (400) begin
      r = $urandom_range(0, 3);
      case (r)
        0: lv = 16'($urandom);
        1: lv = 16'h5959;
        2: lv = 16'h5958;
        default: lv = 16'($urandom_range(0, 1));
      endcase
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 75, 1'($urandom), lv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_digit_chain.md
UPDOWN_DIGIT_CHAIN -- requirements
Module: updown_digit_chain

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of 4-bit digits, range 1..8.
REQ-002 SHALL have parameter MAXV, default 16'h5959, width 4*NDIG: terminal value per digit (digit k in bits 4k+3:4k), each field 1..15.
REQ-003 SHALL have port Clock, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port Reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port Enable, input, 1: count tick, one step per cycle high.
REQ-006 SHALL have port Up, input, 1: direction, 1 = up, 0 = down.
REQ-007 SHALL have port Clear, input, 1: synchronous zero of all digits and Ovf.
REQ-008 SHALL have port Load, input, 1: synchronous parallel load.
REQ-009 SHALL have port LoadValue, input, 4*NDIG: value for Load.
REQ-010 SHALL have port Salida, output, 4*NDIG: registered digit values, digit 0 in bits 3:0.
REQ-011 SHALL have port Carry, output, 1: combinational chain wrap, for cascading.
REQ-012 SHALL have port Ovf, output, 1: registered sticky wrap flag.

Function
REQ-013 SHALL apply per-cycle priority: Reset > Clear > Load > Enable > hold.
REQ-014 SHALL step digit k when Enable=1 and every digit below k is at its terminal: MAXV field for Up=1, 0 for Up=0; digit 0 steps on every Enable.
REQ-015 SHALL, counting up, increment a stepping digit, or wrap it MAX->0 when at its MAXV field.
REQ-016 SHALL, counting down, decrement a stepping digit, or wrap it 0->MAX.
REQ-017 SHALL resolve the full ripple in a single cycle, e.g. 0959 -> 1000 in one Enable.
REQ-018 SHALL drive Carry = Enable & ~Clear & ~Load & all digits at terminal for the current Up.
REQ-019 SHALL set Ovf on the edge where Carry=1 and hold it until Clear or Reset.
REQ-020 SHALL sample Up every cycle; a direction change takes effect on the next Enable with no extra latency.
REQ-021 SHALL clamp any LoadValue digit above its MAXV field to that field on Load.
REQ-022 SHALL leave Ovf unchanged on Load.
REQ-023 SHALL ensure Enable=0 holds Salida and Ovf and forces Carry=0.

Reset
REQ-024 SHALL set Salida to 0 and Ovf to 0 on a Clock edge with Reset=1, regardless of all other inputs.
REQ-025 SHALL count from 0 on the first Enable after Reset deasserts, with no recovery cycles.

Configuration
REQ-026 SHALL compile down-counting only when UPDOWN_DIGIT_CHAIN_DOWN_EN is defined.
REQ-027 SHALL, without that macro, keep the Up port but ignore it and count up only, with Carry using the MAXV terminal.

Structure
REQ-028 SHALL take DIGIT_W=4 and the default MAXV constant from shared package digit_chain_pkg.
REQ-029 SHALL instantiate one sub-module per digit, mod_digit: one 4-bit wrap counter with step, direction, load, clear and terminal-out.

Verification
REQ-030 SHALL cover: default params, Up=1, 600 Enables from 0000 -> Salida 1000 (BCD mm:ss 10:00), Carry never high.
REQ-031 SHALL cover: Load 5959, Up=1, Enable -> Carry=1 that cycle; next Salida 0000 and Ovf=1.
REQ-032 SHALL cover: Salida 0000, Up=0, Enable (macro on) -> Salida 5959, Carry=1, Ovf=1.
REQ-033 SHALL cover: Load LoadValue 16'hF9A3 -> Salida 5953.
REQ-034 SHALL cover: Reset, Clear, Load and Enable all high at Salida 0427 with Ovf=1 -> Salida 0000 and Ovf=0 next cycle.
REQ-035 SHALL cover: macro off, Up=0, Enable at 0009 -> Salida 0010 (count up, Up ignored).
